avalon_word_copier: RTL and testbench
=====================================

# avalon_word_copier

Avalon-MM master that copies a block of 32-bit words from one word address to another over a single Avalon-MM slave port. It is the initiator side of the on-chip memory slave interface in the SoC. Fabric logic, such as the game-state snapshot or ball/paddle record shuffling, uses it to move small records without the Nios core. An optional read-back verify pass flags write corruption.

## Interface
Parameters:
- ADDR_W, 2, word-address width of the slave (address wraps modulo 2^ADDR_W)
- DATA_W, 32, data width; byteenable width is DATA_W/8
- READ_LATENCY, 1, cycles from accepted read to valid avm_readdata (≥1)
- CNT_W, 3, width of the word-count input

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle request; sampled only in IDLE
- src_addr  in  ADDR_W  first source word address
- dst_addr  in  ADDR_W  first destination word address
- count  in  CNT_W  number of words; 0 = no-op
- busy  out  1  high while a copy is in progress
- done  out  1  one-cycle pulse on completion
- error  out  1  sticky verify-mismatch flag, cleared on accepted start (always 0 without verify)
- avm_address  out  ADDR_W  word address
- avm_chipselect  out  1  high during any read or write request
- avm_read  out  1  read request
- avm_write  out  1  write request
- avm_byteenable  out  DATA_W/8  all ones during any request, 0 otherwise
- avm_writedata  out  DATA_W  captured source word
- avm_readdata  in  DATA_W  slave read data
- avm_waitrequest  in  1  slave stall; tie 0 for fixed-latency memories

## Operation
- Reset state:
  - State is IDLE.
  - All outputs are 0.
  - The internal address, count and data registers are 0.
- Reset asserted mid-copy: abort immediately. An in-flight read is discarded, and no further request is issued.
- States: IDLE → RD_REQ → RD_WAIT → WR_REQ → [VFY_REQ → VFY_WAIT] → RD_REQ or DONE → IDLE.
- IDLE:
  - On start, latch src_addr, dst_addr and count, and clear error.
  - If count=0, go to DONE with no bus activity.
  - Otherwise go to RD_REQ.
  - A start pulse while not in IDLE is ignored.
- RD_REQ: drive chipselect=1, read=1 and address=src. Hold the request until waitrequest=0, then go to RD_WAIT.
- RD_WAIT: wait READ_LATENCY cycles. Capture avm_readdata on the last of them into the data register.
- WR_REQ:
  - Drive chipselect=1, write=1, address=dst and writedata=data register.
  - Hold the request until waitrequest=0.
  - On acceptance, increment src and dst (modulo 2^ADDR_W) and decrement the remaining count.
  - Then go to RD_REQ if words remain, else to DONE.
- DONE: done=1 and busy=0 for exactly one cycle, then IDLE.
- busy is 1 in every state except IDLE and DONE.
- Request outputs are held stable while waitrequest=1.
- Address overlap between source and destination is not detected. The copy is strictly ascending, word by word.

## Timing
- Start sampled at edge k (no waitrequest): first read request in cycle k+1.
- Per word (no verify): 2+READ_LATENCY cycles, consisting of 1 read request, READ_LATENCY wait cycles and 1 write request.
- With N≥1 words, done is high in cycle k+1+N·(2+READ_LATENCY).
- With count=0, done is high in cycle k+1.
- Each waitrequest=1 cycle adds one cycle to the current request.
- A new start is accepted the cycle after done (IDLE). Back-to-back copies have one idle cycle between done and the next request.

## Configuration
- WORD_COPIER_VERIFY_EN defined:
  - After each accepted write, VFY_REQ re-reads dst.
  - VFY_WAIT compares the returned word to the data register after READ_LATENCY cycles.
  - On mismatch, error is set and stays set. The copy continues.
  - Adds 1+READ_LATENCY cycles per word, so done lands at k+1+N·(3+2·READ_LATENCY).
  - Address increment happens after verify.
- Undefined: the VFY states and comparator are removed, and error is tied to 0.

## Test plan
- Memory model with latency 1 and words 0:0xA, 1:0xB. Start with src=0, dst=2, count=2 → mem[2]=0xA, mem[3]=0xB, and done exactly in cycle k+7.
- count=0 → no chipselect ever asserted, done in cycle k+1, busy never high.
- src=3, dst=1, count=2 → reads from addresses 3 then 0 and writes to 1 then 2, checking the wrap.
- waitrequest held high for 3 cycles on the first write → address, writedata and write stay stable through the stall, and done is delayed by 3 cycles.
- Reset pulsed during RD_WAIT → all outputs are 0 on the next cycle, no write occurs, and a subsequent start copies correctly.
- With VERIFY_EN, the model corrupts mem[2] on write → error=1 at done, the remaining words are still copied, and error clears on the next start.

Source files
------------

// File: rtl/avalon_word_copier.sv
// Avalon-MM master that copies `count` words from src to dst, one read/write pair per word.
// Optional build macro WORD_COPIER_VERIFY_EN adds a read-back pass that sets a sticky error flag.
module avalon_word_copier #(
  parameter int ADDR_W       = 2,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1,
  parameter int CNT_W        = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     src_addr,
  input  logic [ADDR_W-1:0]     dst_addr,
  input  logic [CNT_W-1:0]      count,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_W-1:0]     avm_address,
  output logic                  avm_chipselect,
  output logic                  avm_read,
  output logic                  avm_write,
  output logic [DATA_W/8-1:0]   avm_byteenable,
  output logic [DATA_W-1:0]     avm_writedata,
  input  logic [DATA_W-1:0]     avm_readdata,
  input  logic                  avm_waitrequest
);

  localparam int               LAT_W    = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_RD_REQ  = 3'd1;
  localparam logic [2:0] S_RD_WAIT = 3'd2;
  localparam logic [2:0] S_WR_REQ  = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
`ifdef WORD_COPIER_VERIFY_EN
  localparam logic [2:0] S_VFY_REQ  = 3'd5;
  localparam logic [2:0] S_VFY_WAIT = 3'd6;
`endif

  logic [2:0]        state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic              last_word;
`ifdef WORD_COPIER_VERIFY_EN
  logic              error_q, error_d;
`endif

  assign last_word = (cnt_q == CNT_W'(1));

  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    lat_d   = lat_q;
`ifdef WORD_COPIER_VERIFY_EN
    error_d = error_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          cnt_d   = count;
`ifdef WORD_COPIER_VERIFY_EN
          error_d = 1'b0;
`endif
          state_d = (count == '0) ? S_DONE : S_RD_REQ;
        end
      end
      S_RD_REQ: begin
        if (!avm_waitrequest) begin
          lat_d   = '0;
          state_d = S_RD_WAIT;
        end
      end
      S_RD_WAIT: begin
        if (lat_q == LAT_LAST) begin
          data_d  = avm_readdata;
          state_d = S_WR_REQ;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      S_WR_REQ: begin
        if (!avm_waitrequest) begin
`ifdef WORD_COPIER_VERIFY_EN
          state_d = S_VFY_REQ;
`else
          src_d   = src_q + 1'b1;
          dst_d   = dst_q + 1'b1;
          cnt_d   = cnt_q - 1'b1;
          state_d = last_word ? S_DONE : S_RD_REQ;
`endif
        end
      end
`ifdef WORD_COPIER_VERIFY_EN
      S_VFY_REQ: begin
        if (!avm_waitrequest) begin
          lat_d   = '0;
          state_d = S_VFY_WAIT;
        end
      end
      S_VFY_WAIT: begin
        // A mismatch is only recorded; the copy still runs to completion.
        if (lat_q == LAT_LAST) begin
          if (avm_readdata != data_q) error_d = 1'b1;
          src_d   = src_q + 1'b1;
          dst_d   = dst_q + 1'b1;
          cnt_d   = cnt_q - 1'b1;
          state_d = last_word ? S_DONE : S_RD_REQ;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      src_q   <= '0;
      dst_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      lat_q   <= '0;
`ifdef WORD_COPIER_VERIFY_EN
      error_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      lat_q   <= lat_d;
`ifdef WORD_COPIER_VERIFY_EN
      error_q <= error_d;
`endif
    end
  end

  // Bus outputs decode straight from registered state, so they stay put during a stall.
  always_comb begin
    avm_chipselect = 1'b0;
    avm_read       = 1'b0;
    avm_write      = 1'b0;
    avm_address    = '0;
    avm_byteenable = '0;
    avm_writedata  = '0;
    case (state_q)
      S_RD_REQ: begin
        avm_chipselect = 1'b1;
        avm_read       = 1'b1;
        avm_address    = src_q;
        avm_byteenable = '1;
      end
      S_WR_REQ: begin
        avm_chipselect = 1'b1;
        avm_write      = 1'b1;
        avm_address    = dst_q;
        avm_byteenable = '1;
        avm_writedata  = data_q;
      end
`ifdef WORD_COPIER_VERIFY_EN
      S_VFY_REQ: begin
        avm_chipselect = 1'b1;
        avm_read       = 1'b1;
        avm_address    = dst_q;
        avm_byteenable = '1;
      end
`endif
      default: ;
    endcase
  end

  assign busy = (state_q != S_IDLE) && (state_q != S_DONE);
  assign done = (state_q == S_DONE);
`ifdef WORD_COPIER_VERIFY_EN
  assign error = error_q;
`else
  assign error = 1'b0;
`endif

endmodule

// File: tb/tb_avalon_word_copier.sv
// Directed bench for avalon_word_copier against a 4-word, latency-1 memory model.
module tb_avalon_word_copier;

`ifdef WORD_COPIER_VERIFY_EN
  localparam int WORD_CYC  = 5;
  localparam int RD_STRIDE = 2;
`else
  localparam int WORD_CYC  = 3;
  localparam int RD_STRIDE = 1;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  src_addr = '0;
  logic [1:0]  dst_addr = '0;
  logic [2:0]  count = '0;
  logic        busy, done, error;
  logic [1:0]  avm_address;
  logic        avm_chipselect, avm_read, avm_write;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata;
  logic        avm_waitrequest;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  avalon_word_copier dut (
    .clk(clk), .reset(reset), .start(start),
    .src_addr(src_addr), .dst_addr(dst_addr), .count(count),
    .busy(busy), .done(done), .error(error),
    .avm_address(avm_address), .avm_chipselect(avm_chipselect),
    .avm_read(avm_read), .avm_write(avm_write),
    .avm_byteenable(avm_byteenable), .avm_writedata(avm_writedata),
    .avm_readdata(avm_readdata), .avm_waitrequest(avm_waitrequest)
  );

  always #5 clk = ~clk;

  // Memory model: read data valid one cycle after acceptance; optional corruption of address 2.
  logic [31:0] mem [0:3];
  logic [31:0] rd_data = '0;
  logic        corrupt_en = 1'b0;
  int          stall_left = 0;
  int          cyc = 0;

  assign avm_readdata    = rd_data;
  assign avm_waitrequest = (stall_left != 0) && avm_write;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (avm_waitrequest) stall_left <= stall_left - 1;
    if (avm_chipselect && avm_read && !avm_waitrequest) rd_data <= mem[avm_address];
    if (avm_chipselect && avm_write && !avm_waitrequest)
      mem[avm_address] <= (corrupt_en && avm_address == 2'd2) ? (avm_writedata ^ 32'hFF)
                                                               : avm_writedata;
  end

  // Bus monitor: logs accepted transfers and activity counts.
  logic [1:0]  rd_addr [0:255];
  int          rd_cyc  [0:255];
  logic [1:0]  wr_addr [0:255];
  logic [31:0] wr_data [0:255];
  int rd_n = 0, wr_n = 0, cs_cnt = 0, busy_cnt = 0;

  always @(negedge clk) begin
    if (avm_chipselect && avm_read && !avm_waitrequest) begin
      rd_addr[rd_n & 255] <= avm_address;
      rd_cyc[rd_n & 255]  <= cyc;
      rd_n <= rd_n + 1;
    end
    if (avm_chipselect && avm_write && !avm_waitrequest) begin
      wr_addr[wr_n & 255] <= avm_address;
      wr_data[wr_n & 255] <= avm_writedata;
      wr_n <= wr_n + 1;
    end
    if (avm_chipselect) cs_cnt <= cs_cnt + 1;
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  task automatic load_mem(input logic [31:0] a, b, c, d);
    @(negedge clk);
    mem[0] <= a; mem[1] <= b; mem[2] <= c; mem[3] <= d;
  endtask

  task automatic drive_start(input logic [1:0] s, input logic [1:0] dd, input logic [2:0] n,
                             output int start_cyc);
    @(negedge clk);
    start = 1'b1; src_addr = s; dst_addr = dd; count = n;
    start_cyc = cyc + 1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int done_cyc, output bit timed_out);
    timed_out = 1'b1;
    done_cyc  = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (done) begin
        done_cyc  = cyc;
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset;
    logic [45:0] outs;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    outs = {busy, done, error, avm_address, avm_chipselect, avm_read, avm_write,
            avm_byteenable, avm_writedata};
    chk_cnt++;
    if (outs !== '0) $display("FAIL reset_outputs: got %h expected 0", outs);
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
    chk_cnt++;
    if ({busy, avm_chipselect} !== 2'b00) $display("FAIL idle_after_reset: busy/cs %b expected 00", {busy, avm_chipselect});
    else pass_cnt++;
  endtask

  task automatic test_basic_copy;
    int sc, dc, rb, wb; bit to;
    load_mem(32'hA, 32'hB, 32'h0, 32'h0);
    rb = rd_n; wb = wr_n;
    drive_start(2'd0, 2'd2, 3'd2, sc);
    wait_done(dc, to);
    chk_cnt++;
    if (to !== 1'b0) $display("FAIL basic_timeout: done not seen within 200 cycles");
    else pass_cnt++;
    chk_cnt++;
    if (dc - sc !== 2 * WORD_CYC) $display("FAIL basic_latency: got %0d expected %0d", dc - sc, 2 * WORD_CYC);
    else pass_cnt++;
    chk_cnt++;
    if (rd_cyc[rb] - sc !== 0) $display("FAIL first_read_cycle: got +%0d expected +0", rd_cyc[rb] - sc);
    else pass_cnt++;
    chk_cnt++;
    if ({rd_addr[rb], rd_addr[rb + RD_STRIDE]} !== {2'd0, 2'd1}) $display("FAIL basic_read_addrs: got %0d,%0d expected 0,1", rd_addr[rb], rd_addr[rb + RD_STRIDE]);
    else pass_cnt++;
    chk_cnt++;
    if ({wr_addr[wb], wr_addr[wb + 1]} !== {2'd2, 2'd3}) $display("FAIL basic_write_addrs: got %0d,%0d expected 2,3", wr_addr[wb], wr_addr[wb + 1]);
    else pass_cnt++;
    chk_cnt++;
    if ({mem[2], mem[3]} !== {32'hA, 32'hB}) $display("FAIL basic_mem: got %h,%h expected a,b", mem[2], mem[3]);
    else pass_cnt++;
    chk_cnt++;
    if ({busy, error} !== 2'b00) $display("FAIL basic_flags_at_done: busy/error %b expected 00", {busy, error});
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (done !== 1'b0) $display("FAIL done_single_pulse: done %b expected 0", done);
    else pass_cnt++;
  endtask

  task automatic test_zero_count;
    int sc, dc, cb, bb; bit to;
    cb = cs_cnt; bb = busy_cnt;
    drive_start(2'd1, 2'd2, 3'd0, sc);
    wait_done(dc, to);
    chk_cnt++;
    if (to !== 1'b0 || dc - sc !== 0) $display("FAIL zero_latency: got %0d (timeout %0d) expected 0", dc - sc, to);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (cs_cnt - cb !== 0) $display("FAIL zero_no_chipselect: got %0d cycles expected 0", cs_cnt - cb);
    else pass_cnt++;
    chk_cnt++;
    if (busy_cnt - bb !== 0) $display("FAIL zero_no_busy: got %0d cycles expected 0", busy_cnt - bb);
    else pass_cnt++;
  endtask

  task automatic test_wrap;
    int sc, dc, rb, wb; bit to;
    load_mem(32'h10, 32'h11, 32'h12, 32'h13);
    rb = rd_n; wb = wr_n;
    drive_start(2'd3, 2'd1, 3'd2, sc);
    wait_done(dc, to);
    chk_cnt++;
    if (to !== 1'b0 || dc - sc !== 2 * WORD_CYC) $display("FAIL wrap_latency: got %0d expected %0d", dc - sc, 2 * WORD_CYC);
    else pass_cnt++;
    chk_cnt++;
    if ({rd_addr[rb], rd_addr[rb + RD_STRIDE]} !== {2'd3, 2'd0}) $display("FAIL wrap_read_addrs: got %0d,%0d expected 3,0", rd_addr[rb], rd_addr[rb + RD_STRIDE]);
    else pass_cnt++;
    chk_cnt++;
    if ({wr_addr[wb], wr_addr[wb + 1]} !== {2'd1, 2'd2}) $display("FAIL wrap_write_addrs: got %0d,%0d expected 1,2", wr_addr[wb], wr_addr[wb + 1]);
    else pass_cnt++;
    chk_cnt++;
    if ({wr_data[wb], wr_data[wb + 1]} !== {32'h13, 32'h10}) $display("FAIL wrap_write_data: got %h,%h expected 13,10", wr_data[wb], wr_data[wb + 1]);
    else pass_cnt++;
    chk_cnt++;
    if ({mem[1], mem[2]} !== {32'h13, 32'h10}) $display("FAIL wrap_mem: got %h,%h expected 13,10", mem[1], mem[2]);
    else pass_cnt++;
  endtask

  task automatic test_write_stall;
    int sc, dc; bit to, found;
    logic [39:0] obs;
    load_mem(32'hA, 32'hB, 32'h0, 32'h0);
    @(negedge clk);
    stall_left <= 3;
    drive_start(2'd0, 2'd2, 3'd2, sc);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (avm_write) found = 1'b1;
    end
    chk_cnt++;
    if (!(found && avm_waitrequest)) $display("FAIL stall_seen: write %b waitrequest %b expected 1,1", found, avm_waitrequest);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      obs = {avm_chipselect, avm_write, avm_address, avm_byteenable, avm_writedata};
      chk_cnt++;
      if (obs !== {1'b1, 1'b1, 2'd2, 4'hF, 32'hA}) $display("FAIL stall_stable_%0d: got %h expected %h", i, obs, {1'b1, 1'b1, 2'd2, 4'hF, 32'hA});
      else pass_cnt++;
    end
    wait_done(dc, to);
    chk_cnt++;
    if (to !== 1'b0 || dc - sc !== 2 * WORD_CYC + 3) $display("FAIL stall_latency: got %0d expected %0d", dc - sc, 2 * WORD_CYC + 3);
    else pass_cnt++;
    chk_cnt++;
    if ({mem[2], mem[3]} !== {32'hA, 32'hB}) $display("FAIL stall_mem: got %h,%h expected a,b", mem[2], mem[3]);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_copy;
    int sc, dc, wb; bit to;
    logic [45:0] outs;
    load_mem(32'h21, 32'h22, 32'h23, 32'h24);
    wb = wr_n;
    drive_start(2'd0, 2'd3, 3'd2, sc);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    outs = {busy, done, error, avm_address, avm_chipselect, avm_read, avm_write,
            avm_byteenable, avm_writedata};
    chk_cnt++;
    if (outs !== '0) $display("FAIL midreset_outputs: got %h expected 0", outs);
    else pass_cnt++;
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk_cnt++;
    if (wr_n - wb !== 0 || mem[3] !== 32'h24) $display("FAIL midreset_no_write: writes %0d mem3 %h expected 0,24", wr_n - wb, mem[3]);
    else pass_cnt++;
    drive_start(2'd1, 2'd3, 3'd1, sc);
    wait_done(dc, to);
    chk_cnt++;
    if (to !== 1'b0 || dc - sc !== WORD_CYC || mem[3] !== 32'h22) $display("FAIL midreset_recopy: latency %0d mem3 %h expected %0d,22", dc - sc, mem[3], WORD_CYC);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    int sc, dc, sc2, dc2; bit to, to2;
    load_mem(32'h31, 32'h32, 32'h33, 32'h34);
    drive_start(2'd0, 2'd1, 3'd1, sc);
    // A start pulse while busy must not disturb the running copy.
    @(negedge clk);
    start = 1'b1; src_addr = 2'd2; dst_addr = 2'd3; count = 3'd3;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(dc, to);
    chk_cnt++;
    if (to !== 1'b0 || dc - sc !== WORD_CYC || mem[3] !== 32'h34) $display("FAIL ignore_start: latency %0d mem3 %h expected %0d,34", dc - sc, mem[3], WORD_CYC);
    else pass_cnt++;
    drive_start(2'd1, 2'd2, 3'd1, sc2);
    chk_cnt++;
    if (sc2 - dc !== 2) $display("FAIL b2b_accept: start edge +%0d after done expected +2", sc2 - dc);
    else pass_cnt++;
    wait_done(dc2, to2);
    chk_cnt++;
    if (to2 !== 1'b0 || dc2 - sc2 !== WORD_CYC || mem[2] !== 32'h31) $display("FAIL b2b_copy: latency %0d mem2 %h expected %0d,31", dc2 - sc2, mem[2], WORD_CYC);
    else pass_cnt++;
  endtask

  task automatic test_verify;
    int sc, dc; bit to;
    logic exp_err;
`ifdef WORD_COPIER_VERIFY_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    load_mem(32'h41, 32'h42, 32'h0, 32'h0);
    corrupt_en <= 1'b1;
    drive_start(2'd0, 2'd2, 3'd2, sc);
    wait_done(dc, to);
    chk_cnt++;
    if (to !== 1'b0 || dc - sc !== 2 * WORD_CYC) $display("FAIL verify_latency: got %0d expected %0d", dc - sc, 2 * WORD_CYC);
    else pass_cnt++;
    chk_cnt++;
    if (error !== exp_err) $display("FAIL verify_error_at_done: got %b expected %b", error, exp_err);
    else pass_cnt++;
    chk_cnt++;
    if ({mem[2], mem[3]} !== {32'hBE, 32'h42}) $display("FAIL verify_mem: got %h,%h expected be,42", mem[2], mem[3]);
    else pass_cnt++;
    @(negedge clk);
    chk_cnt++;
    if (error !== exp_err) $display("FAIL verify_error_sticky: got %b expected %b", error, exp_err);
    else pass_cnt++;
    corrupt_en <= 1'b0;
    drive_start(2'd0, 2'd1, 3'd0, sc);
    wait_done(dc, to);
    chk_cnt++;
    if (to !== 1'b0 || error !== 1'b0) $display("FAIL verify_error_clear: got %b expected 0", error);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_basic_copy();
    test_zero_count();
    test_wrap();
    test_write_stall();
    test_reset_mid_copy();
    test_back_to_back();
    test_verify();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
